// File: rtl/cycle_counter_pkg.sv
// Shared constants for the cycle/instret counter block.
//   - Counter widths (full count and each half).
//   - Encodings of the counter-register write address (csr_addr_in).
package cycle_counter_pkg;

    localparam int unsigned HalfWidth    = 32;
    localparam int unsigned CountWidth   = 2 * HalfWidth;
    localparam int unsigned InhibitWidth = 2;
    localparam int unsigned AddrWidth    = 3;

    typedef enum logic [AddrWidth-1:0] {
        CsrMcycle        = 3'b000,
        CsrMcycleh       = 3'b001,
        CsrMinstret      = 3'b010,
        CsrMinstreth     = 3'b011,
        CsrMcountinhibit = 3'b100
    } csr_addr_e;

endpackage

// File: rtl/cycle_counter_if.sv
// Bus bundle for cycle_counter.
//   instr_retired_in   : one instruction retired this cycle
//   csr_write_in       : counter register write strobe
//   csr_addr_in        : write target (see csr_addr_e)
//   csr_write_value_in : write data
//   cycle_out          : coherent 64-bit cycle count
//   instret_out        : coherent 64-bit retired-instruction count
//   inhibit_out        : bit0 inhibits cycle, bit1 inhibits instret
// master drives the requests and observes the counts; slave is the counter block.
interface cycle_counter_if;
    import cycle_counter_pkg::*;

    logic                    instr_retired_in;
    logic                    csr_write_in;
    logic [AddrWidth-1:0]    csr_addr_in;
    logic [HalfWidth-1:0]    csr_write_value_in;
    logic [CountWidth-1:0]   cycle_out;
    logic [CountWidth-1:0]   instret_out;
    logic [InhibitWidth-1:0] inhibit_out;

    modport master (
        output instr_retired_in,
        output csr_write_in,
        output csr_addr_in,
        output csr_write_value_in,
        input  cycle_out,
        input  instret_out,
        input  inhibit_out
    );

    modport slave (
        input  instr_retired_in,
        input  csr_write_in,
        input  csr_addr_in,
        input  csr_write_value_in,
        output cycle_out,
        output instret_out,
        output inhibit_out
    );

endinterface

// File: rtl/cycle_counter_counter64_split.sv
// counter64_split: 64-bit counter built from two 32-bit halves with a registered carry.
//   clk, reset_n : clock, synchronous active-low reset
//   inc_en       : increment the low half this cycle
//   low_we       : load wdata into the low half (wins over increment, kills its carry)
//   high_we      : load wdata into the high half (pending carry is discarded)
//   wdata        : write data for either half
//   value        : {high, low delayed one cycle}, never shows a half-applied wrap
module counter64_split
    import cycle_counter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  inc_en,
    input  logic                  low_we,
    input  logic                  high_we,
    input  logic [HalfWidth-1:0]  wdata,
    output logic [CountWidth-1:0] value
);

    logic [HalfWidth-1:0] low_q, low_d;
    logic [HalfWidth-1:0] high_q, high_d;
    logic [HalfWidth-1:0] low_dly_q;
    logic                 carry_q, carry_d;

    always_comb begin
        low_d   = low_q;
        carry_d = 1'b0;
        if (low_we) begin
            low_d = wdata;
        end else if (inc_en) begin
            {carry_d, low_d} = {1'b0, low_q} + {{HalfWidth{1'b0}}, 1'b1};
        end
        // Carry is applied one edge after the wrap, independent of inhibit.
        high_d = high_we ? wdata : high_q + {{(HalfWidth-1){1'b0}}, carry_q};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            low_q     <= '0;
            high_q    <= '0;
            carry_q   <= 1'b0;
            low_dly_q <= '0;
        end else begin
            low_q     <= low_d;
            high_q    <= high_d;
            carry_q   <= carry_d;
            low_dly_q <= low_q;
        end
    end

    // Low is delayed so it lines up with the high half that has absorbed its carry.
    assign value = {high_q, low_dly_q};

endmodule

// File: rtl/cycle_counter.sv
// cycle_counter: mcycle / minstret counters with mcountinhibit.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : cycle_counter_if.slave (write port in, counts and inhibit out)
// Build option: define COUNTER_INSTRET_EN to build the retired-instruction counter;
// otherwise instret_out is 0, minstret/minstreth writes are ignored and inhibit_out[1] is 0.
module cycle_counter
    import cycle_counter_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    cycle_counter_if.slave bus
);

    logic                  wr_mcycle, wr_mcycleh, wr_inhibit;
    logic                  inhibit_cycle_q;
    logic [CountWidth-1:0] cycle_value;

    assign wr_mcycle  = bus.csr_write_in && (bus.csr_addr_in == CsrMcycle);
    assign wr_mcycleh = bus.csr_write_in && (bus.csr_addr_in == CsrMcycleh);
    assign wr_inhibit = bus.csr_write_in && (bus.csr_addr_in == CsrMcountinhibit);

    // Inhibit is registered, so a write only gates increments from the next cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inhibit_cycle_q <= 1'b0;
        end else if (wr_inhibit) begin
            inhibit_cycle_q <= bus.csr_write_value_in[0];
        end
    end

    counter64_split u_cycle (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_en  (!inhibit_cycle_q),
        .low_we  (wr_mcycle),
        .high_we (wr_mcycleh),
        .wdata   (bus.csr_write_value_in),
        .value   (cycle_value)
    );

    assign bus.cycle_out = cycle_value;

`ifdef COUNTER_INSTRET_EN
    logic                  wr_minstret, wr_minstreth;
    logic                  inhibit_instret_q;
    logic [CountWidth-1:0] instret_value;

    assign wr_minstret  = bus.csr_write_in && (bus.csr_addr_in == CsrMinstret);
    assign wr_minstreth = bus.csr_write_in && (bus.csr_addr_in == CsrMinstreth);

    // mcountinhibit bit 2 (IR) maps onto inhibit_out[1].
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inhibit_instret_q <= 1'b0;
        end else if (wr_inhibit) begin
            inhibit_instret_q <= bus.csr_write_value_in[2];
        end
    end

    counter64_split u_instret (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_en  (bus.instr_retired_in && !inhibit_instret_q),
        .low_we  (wr_minstret),
        .high_we (wr_minstreth),
        .wdata   (bus.csr_write_value_in),
        .value   (instret_value)
    );

    assign bus.instret_out = instret_value;
    assign bus.inhibit_out = {inhibit_instret_q, inhibit_cycle_q};
`else
    logic unused_instret;
    assign unused_instret  = bus.instr_retired_in ^ bus.csr_write_value_in[2];
    assign bus.instret_out = '0;
    assign bus.inhibit_out = {1'b0, inhibit_cycle_q};
`endif

endmodule
